// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the multi-slot TDM receiver.
package tdm_pkg;

   typedef enum logic [1:0] {
      HUNT,
      CHECK,
      LOCKED
   } state_e;

   function automatic int frame_bits(input int channels, input int slot_bits);
      return channels * slot_bits;
   endfunction

   // Width of a counter that spans 0 .. frameBits-1.
   function automatic int idx_width(input int frameBits);
      return (frameBits > 2) ? $clog2(frameBits) : 1;
   endfunction

endpackage

// File: rtl/tdm_rx_multi_if.sv
// Serial-side inputs and parallel-sample outputs of tdm_rx_multi.
// err_count exists only when TDM_RX_ERR_CNT_EN is defined.
interface tdm_rx_multi_if #(
   parameter int CHANNELS    = 2,
   parameter int SAMPLE_BITS = 16
);

   logic                            bit_en;
   logic                            fsync;
   logic                            tdm_in;
   logic [CHANNELS*SAMPLE_BITS-1:0] ch_data;
   logic                            frame_valid;
   logic                            locked;
   logic                            sync_err;

`ifdef TDM_RX_ERR_CNT_EN
   logic [15:0]                     err_count;

   modport master (
      output bit_en, fsync, tdm_in,
      input  ch_data, frame_valid, locked, sync_err, err_count
   );

   modport slave (
      input  bit_en, fsync, tdm_in,
      output ch_data, frame_valid, locked, sync_err, err_count
   );
`else
   modport master (
      output bit_en, fsync, tdm_in,
      input  ch_data, frame_valid, locked, sync_err
   );

   modport slave (
      input  bit_en, fsync, tdm_in,
      output ch_data, frame_valid, locked, sync_err
   );
`endif

endinterface

// File: rtl/tdm_fsync_tracker.sv
// Frame-sync edge detect, frame bit counter and HUNT/CHECK/LOCKED alignment FSM.
// idx_o/state_o describe the bit being sampled in the current bit_en cycle.
module tdm_fsync_tracker
   import tdm_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int SLOT_BITS = 32
) (
   input  logic                                         mclk,
   input  logic                                         rst,
   input  logic                                         bit_en_i,
   input  logic                                         fsync_i,
   output logic [idx_width(frame_bits(CHANNELS, SLOT_BITS))-1:0] idx_o,
   output state_e                                       state_o,
   output logic                                         locked_o,
   output logic                                         sync_err_o
);

   localparam int FB = frame_bits(CHANNELS, SLOT_BITS);
   localparam int IW = idx_width(FB);
   localparam logic [IW-1:0] LAST_IDX = IW'(FB - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            fsPrev_q;
   logic            syncErr_q, syncErr_d;
   logic            edgeDet;

   assign edgeDet = bit_en_i & fsync_i & ~fsPrev_q;

   // An fsync edge always marks bit 0 of a new frame reference; what it means
   // for alignment depends on where the running counter expected it.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      syncErr_d = 1'b0;
      if (bit_en_i) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         unique case (state_q)
            HUNT: begin
               idx_d = '0;
               if (edgeDet) begin
                  state_d = CHECK;
                  idx_d   = IDX_ONE;
               end
            end
            CHECK: begin
               if (edgeDet) begin
                  idx_d = IDX_ONE;
                  if (idx_q == '0) begin
                     state_d = LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (edgeDet) begin
                  idx_d = IDX_ONE;
                  if (idx_q != '0) begin
                     syncErr_d = 1'b1;
                     state_d   = CHECK;
                  end
               end else if (idx_q == '0) begin
                  syncErr_d = 1'b1;
                  state_d   = HUNT;
                  idx_d     = '0;
               end
            end
            default: begin
               state_d = HUNT;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q   <= HUNT;
         idx_q     <= '0;
         fsPrev_q  <= 1'b0;
         syncErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         syncErr_q <= syncErr_d;
         if (bit_en_i) begin
            fsPrev_q <= fsync_i;
         end
      end
   end

   assign idx_o      = edgeDet ? '0 : idx_q;
   assign state_o    = state_d;
   assign locked_o   = (state_q == LOCKED);
   assign sync_err_o = syncErr_q;

endmodule

// File: rtl/tdm_rx_multi.sv
// Parametrised TDM receiver: deserialises CHANNELS slots per frame into ch_data.
// Define TDM_RX_ERR_CNT_EN to add the saturating err_count output.
module tdm_rx_multi
   import tdm_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int SLOT_BITS   = 32,
   parameter int SAMPLE_BITS = 16,
   parameter int FSYNC_DELAY = 1
) (
   input  logic           mclk,
   input  logic           rst,
   tdm_rx_multi_if.slave  bus
);

   localparam int FB  = frame_bits(CHANNELS, SLOT_BITS);
   localparam int IW  = idx_width(FB);
   localparam int IWP = IW + 1;
   localparam int CW  = CHANNELS * SAMPLE_BITS;

   localparam logic [IW:0] SLOT_W    = IWP'(SLOT_BITS);
   localparam logic [IW:0] CAP_LO    = IWP'(FSYNC_DELAY);
   localparam logic [IW:0] SAMPLE_W  = IWP'(SAMPLE_BITS);
   localparam logic [IW:0] CAP_LAST  = IWP'(SAMPLE_BITS - 1);
   localparam logic [IW:0] LAST_SLOT = IWP'(CHANNELS - 1);

   logic [IW-1:0]          bitIdx;
   state_e                 bitState;
   logic                   syncErr;
   logic [IW:0]            idxW, slotNum, slotOff, capOff;
   logic                   capActive, capEn, capLsb;
   logic [SAMPLE_BITS-1:0] shift_q, shift_d, sample;
   logic [SAMPLE_BITS-1:0] stage_q [CHANNELS];
   logic [SAMPLE_BITS-1:0] stage_d [CHANNELS];
   logic [CW-1:0]          chData_q, chData_d;
   logic                   frameValid_q, frameValid_d;

   tdm_fsync_tracker #(
      .CHANNELS  (CHANNELS),
      .SLOT_BITS (SLOT_BITS)
   ) u_tracker (
      .mclk       (mclk),
      .rst        (rst),
      .bit_en_i   (bus.bit_en),
      .fsync_i    (bus.fsync),
      .idx_o      (bitIdx),
      .state_o    (bitState),
      .locked_o   (bus.locked),
      .sync_err_o (syncErr)
   );

   // capOff wraps to a large value for bits before the capture window, so a
   // single compare bounds both ends.
   assign idxW      = {1'b0, bitIdx};
   assign slotNum   = idxW / SLOT_W;
   assign slotOff   = idxW % SLOT_W;
   assign capOff    = slotOff - CAP_LO;
   assign capActive = bus.bit_en && (bitState != HUNT);
   assign capEn     = capActive && (capOff < SAMPLE_W);
   assign capLsb    = capActive && (capOff == CAP_LAST);
   assign sample    = {shift_q[SAMPLE_BITS-2:0], bus.tdm_in};

   always_comb begin
      shift_d      = shift_q;
      stage_d      = stage_q;
      chData_d     = chData_q;
      frameValid_d = 1'b0;
      if (capEn) begin
         shift_d = sample;
      end
      if (capLsb) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (slotNum == IWP'(k)) begin
               stage_d[k] = sample;
            end
         end
         if ((slotNum == LAST_SLOT) && (bitState == LOCKED)) begin
            for (int k = 0; k < CHANNELS; k++) begin
               chData_d[k*SAMPLE_BITS +: SAMPLE_BITS] = stage_d[k];
            end
            frameValid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         shift_q      <= '0;
         chData_q     <= '0;
         frameValid_q <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         shift_q      <= shift_d;
         stage_q      <= stage_d;
         chData_q     <= chData_d;
         frameValid_q <= frameValid_d;
      end
   end

   assign bus.ch_data     = chData_q;
   assign bus.frame_valid = frameValid_q;
   assign bus.sync_err    = syncErr;

`ifdef TDM_RX_ERR_CNT_EN
   logic [15:0] errCount_q;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         errCount_q <= '0;
      end else if (syncErr && (errCount_q != 16'hFFFF)) begin
         errCount_q <= errCount_q + 16'd1;
      end
   end

   assign bus.err_count = errCount_q;
`endif

endmodule

// File: tb/tb_tdm_rx_multi.sv
// Bench for tdm_rx_multi: default 2x32/16 instance against a frame-level model,
// plus an 8-slot DSP-mode instance with directed slot patterns.
module tb_tdm_rx_multi;

   localparam int CH       = 2;
   localparam int SLOT     = 32;
   localparam int SB       = 16;
   localparam int FD       = 1;
   localparam int FB       = CH * SLOT;
   localparam int LAST_LSB = (CH - 1) * SLOT + FD + SB - 1;
   localparam int WCH      = 8;
   localparam int WSB      = 24;

   logic mclk;
   logic rst;
   int   vectors;
   int   miscompares;

   tdm_rx_multi_if #(.CHANNELS(CH),  .SAMPLE_BITS(SB))  bus  ();
   tdm_rx_multi_if #(.CHANNELS(WCH), .SAMPLE_BITS(WSB)) wBus ();

   tdm_rx_multi #(
      .CHANNELS(CH), .SLOT_BITS(SLOT), .SAMPLE_BITS(SB), .FSYNC_DELAY(FD)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   tdm_rx_multi #(
      .CHANNELS(WCH), .SLOT_BITS(32), .SAMPLE_BITS(WSB), .FSYNC_DELAY(0)
   ) wdut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (wBus)
   );

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   // Reference model: mode 0/1/2 = hunting/checking/locked, mRef = absolute
   // bit number of the current frame reference edge, mBits = every bit sent.
   int           mMode;
   int           mRef;
   logic         mPrevFs;
   logic         mBits[$];
   int           mErrs;
   logic         expFv, expSe, expLk;
   logic [31:0]  expData;

   task automatic modelReset();
      mMode   = 0;
      mRef    = 0;
      mPrevFs = 1'b0;
      mErrs   = 0;
      expFv   = 1'b0;
      expSe   = 1'b0;
      expLk   = 1'b0;
      expData = '0;
   endtask

   task automatic modelStep(input logic fs, input logic d);
      int   n;
      int   pos;
      logic isEdge;
      mBits.push_back(d);
      n       = mBits.size() - 1;
      isEdge  = fs && !mPrevFs;
      mPrevFs = fs;
      expFv   = 1'b0;
      expSe   = 1'b0;
      pos     = (n - mRef) % FB;
      case (mMode)
         0: if (isEdge) begin mMode = 1; mRef = n; end
         1: if (isEdge) begin if (pos == 0) mMode = 2; mRef = n; end
         default: begin
            if (isEdge) begin
               if (pos != 0) begin expSe = 1'b1; mMode = 1; end
               mRef = n;
            end else if (pos == 0) begin
               expSe = 1'b1;
               mMode = 0;
            end
         end
      endcase
      if (expSe && mErrs < 65535) mErrs++;
      if (mMode == 2 && ((n - mRef) % FB) == LAST_LSB) begin
         expFv = 1'b1;
         for (int k = 0; k < CH; k++)
            for (int b = 0; b < SB; b++)
               expData[k*SB + SB - 1 - b] = mBits[mRef + k*SLOT + FD + b];
      end
      expLk = (mMode == 2);
   endtask

   function automatic logic bitFor(input int p, input logic [15:0] w0, input logic [15:0] w1);
      int          slot;
      int          off;
      logic [15:0] w;
      slot = p / SLOT;
      off  = (p % SLOT) - FD;
      w    = (slot == 0) ? w0 : w1;
      if (off >= 0 && off < SB) return w[SB - 1 - off];
      return logic'($urandom_range(0, 1));
   endfunction

   // Entered and left on a falling edge; the bit is sampled by the rising edge between.
   task automatic driveBit(input logic fs, input logic d, input int gap);
      repeat (gap) @(negedge mclk);
      bus.bit_en = 1'b1;
      bus.fsync  = fs;
      bus.tdm_in = d;
      @(negedge mclk);
      bus.bit_en = 1'b0;
      modelStep(fs, d);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge mclk);
      vectors++;
      if ({bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data} !== 35'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data});
      end
      vectors++;
      if ({wBus.frame_valid, wBus.sync_err, wBus.locked, wBus.ch_data} !== 195'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_wide_outputs: got %h expected 0",
                  {wBus.frame_valid, wBus.sync_err, wBus.locked, wBus.ch_data});
      end
      rst = 1'b0;
      modelReset();
      @(negedge mclk);
   endtask

   task automatic test_lock_capture();
      logic [34:0] got, want;
      int          pulses = 0;
      for (int f = 0; f < 4; f++) begin
         for (int p = 0; p < FB; p++) begin
            driveBit(p < 32, bitFor(p, 16'h1234, 16'hABCD), 3);
            got  = {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
            want = {expFv, expSe, expLk, expData};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL lock f%0d p%0d: got %h expected %h", f, p, got, want);
            end
            if (f == 1 && p == 0) begin
               vectors++;
               if (bus.locked !== 1'b1) begin
                  miscompares++;
                  $display("[TB] FAIL lock_second_edge: got %b expected 1", bus.locked);
               end
            end
            if (bus.frame_valid === 1'b1) begin
               pulses++;
               vectors++;
               if (bus.ch_data !== 32'hABCD1234) begin
                  miscompares++;
                  $display("[TB] FAIL lock_data: got %h expected abcd1234", bus.ch_data);
               end
            end
         end
      end
      vectors++;
      if (pulses !== 3) begin
         miscompares++;
         $display("[TB] FAIL lock_pulse_count: got %0d expected 3", pulses);
      end
   endtask

   task automatic test_early_edge();
      logic [34:0] got, want;
      logic [15:0] w0, w1;
      int          errs = 0;
      int          pulses = 0;
      for (int s = 0; s < 4; s++) begin
         w0 = 16'($urandom);
         w1 = 16'($urandom);
         for (int p = 0; p < ((s == 0) ? 40 : FB); p++) begin
            driveBit(p < 32, bitFor(p, w0, w1), 3);
            got  = {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
            want = {expFv, expSe, expLk, expData};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL early s%0d p%0d: got %h expected %h", s, p, got, want);
            end
            if (bus.sync_err === 1'b1) errs++;
            if (bus.frame_valid === 1'b1) pulses++;
         end
      end
      vectors++;
      if ({errs, pulses} !== {32'd1, 32'd2}) begin
         miscompares++;
         $display("[TB] FAIL early_counts: got err=%0d fv=%0d expected err=1 fv=2", errs, pulses);
      end
   endtask

   task automatic test_missing_edge();
      logic [34:0] got, want;
      logic [15:0] w0, w1;
      int          errs = 0;
      int          firstSeg = -1;
      for (int s = 0; s < 4; s++) begin
         w0 = 16'($urandom);
         w1 = 16'($urandom);
         for (int p = 0; p < FB; p++) begin
            driveBit((s != 0) && (p < 32), bitFor(p, w0, w1), 1);
            got  = {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
            want = {expFv, expSe, expLk, expData};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL missing s%0d p%0d: got %h expected %h", s, p, got, want);
            end
            if (bus.sync_err === 1'b1) errs++;
            if (bus.frame_valid === 1'b1 && firstSeg < 0) firstSeg = s;
         end
      end
      vectors++;
      if ({errs, firstSeg} !== {32'd1, 32'd2}) begin
         miscompares++;
         $display("[TB] FAIL missing_counts: got err=%0d first_valid_seg=%0d expected err=1 seg=2",
                  errs, firstSeg);
      end
   endtask

   task automatic test_random_gaps();
      logic [34:0] got, want;
      logic [15:0] w0, w1;
      int          highLen;
      for (int f = 0; f < 8; f++) begin
         w0      = 16'($urandom);
         w1      = 16'($urandom);
         highLen = $urandom_range(1, FB - 1);
         for (int p = 0; p < FB; p++) begin
            driveBit(p < highLen, bitFor(p, w0, w1), $urandom_range(0, 3));
            got  = {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
            want = {expFv, expSe, expLk, expData};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL random f%0d p%0d: got %h expected %h", f, p, got, want);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [34:0] got, want;
      logic [15:0] w0, w1;
      int          pulses = 0;
      for (int p = 0; p < 20; p++) driveBit(p < 32, bitFor(p, 16'h5A5A, 16'hC3C3), 0);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data} !== 35'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_async: got %h expected 0",
                  {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data});
      end
      @(negedge mclk);
      rst = 1'b0;
      modelReset();
      for (int f = 0; f < 3; f++) begin
         w0 = 16'($urandom);
         w1 = 16'($urandom);
         for (int p = 0; p < FB; p++) begin
            driveBit(p < 32, bitFor(p, w0, w1), 2);
            got  = {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
            want = {expFv, expSe, expLk, expData};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL rstmid f%0d p%0d: got %h expected %h", f, p, got, want);
            end
            if (bus.frame_valid === 1'b1) pulses++;
         end
      end
      vectors++;
      if (pulses !== 2) begin
         miscompares++;
         $display("[TB] FAIL rstmid_pulse_count: got %0d expected 2", pulses);
      end
   endtask

   task automatic test_wide_dsp();
      logic [WCH*WSB-1:0] expW;
      logic [23:0]        word;
      logic               expFvW, expLkW;
      int                 off;
      for (int k = 0; k < WCH; k++) expW[k*WSB +: WSB] = 24'h100000 + 24'(k);
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < 256; p++) begin
            word = 24'h100000 + 24'(p / 32);
            off  = p % 32;
            wBus.bit_en = 1'b1;
            wBus.fsync  = (p < 128);
            wBus.tdm_in = (off < WSB) ? word[WSB - 1 - off] : logic'($urandom_range(0, 1));
            @(negedge mclk);
            wBus.bit_en = 1'b0;
            expFvW = (f >= 1) && (p == 247);
            expLkW = (f >= 1);
            vectors++;
            if ({wBus.frame_valid, wBus.locked} !== {expFvW, expLkW}) begin
               miscompares++;
               $display("[TB] FAIL wide f%0d p%0d fv/lk: got %b%b expected %b%b",
                        f, p, wBus.frame_valid, wBus.locked, expFvW, expLkW);
            end
            if (expFvW) begin
               vectors++;
               if (wBus.ch_data !== expW) begin
                  miscompares++;
                  $display("[TB] FAIL wide_data: got %h expected %h", wBus.ch_data, expW);
               end
            end
            @(negedge mclk);
            if (expFvW) begin
               vectors++;
               if (wBus.frame_valid !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL wide_pulse_width: got %b expected 0", wBus.frame_valid);
               end
            end
            repeat (2) @(negedge mclk);
         end
      end
      vectors++;
      if (wBus.ch_data !== expW) begin
         miscompares++;
         $display("[TB] FAIL wide_hold: got %h expected %h", wBus.ch_data, expW);
      end
   endtask

`ifdef TDM_RX_ERR_CNT_EN
   task automatic faultBurst(input int count);
      for (int i = 0; i < count; i++) begin
         for (int p = 0; p < 40; p++) driveBit(p < 32, logic'($urandom_range(0, 1)), 0);
         for (int p = 0; p < FB; p++) driveBit(p < 32, logic'($urandom_range(0, 1)), 0);
      end
      repeat (3) @(negedge mclk);
   endtask

   task automatic test_err_count();
      faultBurst(3);
      vectors++;
      if (bus.err_count !== 16'(mErrs) || mErrs != 3) begin
         miscompares++;
         $display("[TB] FAIL err_count: got %0d expected %0d (model), 3", bus.err_count, mErrs);
      end
      force dut.errCount_q = 16'hFFFE;
      @(negedge mclk);
      release dut.errCount_q;
      faultBurst(3);
      vectors++;
      if (bus.err_count !== 16'hFFFF) begin
         miscompares++;
         $display("[TB] FAIL err_count_sat: got %h expected ffff", bus.err_count);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      bus.bit_en  = 1'b0;
      bus.fsync   = 1'b0;
      bus.tdm_in  = 1'b0;
      wBus.bit_en = 1'b0;
      wBus.fsync  = 1'b0;
      wBus.tdm_in = 1'b0;
      modelReset();
      test_reset();
      test_lock_capture();
      test_early_edge();
      test_missing_edge();
      test_random_gaps();
      test_reset_midframe();
      test_wide_dsp();
`ifdef TDM_RX_ERR_CNT_EN
      test_err_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
